// File: rtl/io_register_bank_if.sv
// Bus bundle for io_register_bank: request/write payload from the master,
// handshake, read data and the flattened register image back from the bank.
interface io_register_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 2
);
  logic                           enable_in;
  logic                           write_in;
  logic [ADDR_WIDTH-1:0]          addr_in;
  logic [1:0]                     mode_in;
  logic [DATA_WIDTH-1:0]          data_in;
  logic [DATA_WIDTH-1:0]          data_out;
  logic                           ready_out;
  logic [NUM_REGS*DATA_WIDTH-1:0] mem_out;

  modport master (
    output enable_in, write_in, addr_in, mode_in, data_in,
    input  data_out, ready_out, mem_out
  );

  modport slave (
    input  enable_in, write_in, addr_in, mode_in, data_in,
    output data_out, ready_out, mem_out
  );
endinterface

// File: rtl/io_register_bank.sv
// Bank of NUM_REGS output registers behind one enable/write port with
// load/set/clear/toggle write modes and a two-state (IDLE/ACK) handshake.
// Optional macro IO_REGISTER_BANK_PULSE_EN turns register NUM_REGS-1 into a
// self-clearing strobe register.
module io_register_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  io_register_bank_if.slave bus
);

  typedef enum logic {IDLE, ACK} state_t;

  typedef enum logic [1:0] {
    MODE_LOAD   = 2'b00,
    MODE_SET    = 2'b01,
    MODE_CLEAR  = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  function automatic logic [DATA_WIDTH-1:0] apply_mode(
    input logic [1:0]            mode,
    input logic [DATA_WIDTH-1:0] cur,
    input logic [DATA_WIDTH-1:0] mask
  );
    logic [DATA_WIDTH-1:0] res;
    case (mode_t'(mode))
      MODE_SET:    res = cur | mask;
      MODE_CLEAR:  res = cur & ~mask;
      MODE_TOGGLE: res = cur ^ mask;
      default:     res = mask;
    endcase
    return res;
  endfunction

  // Next state: one register operation per enable pulse, taken on the IDLE->ACK edge.
  always_comb begin
    // NOTE: every _d signal gets a default before any branch, so no path can infer a latch.
    state_d = state_q;
    rdata_d = rdata_q;
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
`ifdef IO_REGISTER_BANK_PULSE_EN
    // Strobe register: whatever was set last cycle drops now unless rewritten below.
    regs_d[NUM_REGS-1] = '0;
`else
`endif
    case (state_q)
      IDLE: begin
        if (bus.enable_in) begin
          state_d = ACK;
          // Out-of-range reads fall through with 0; out-of-range writes touch nothing.
          if (!bus.write_in) rdata_d = '0;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.addr_in == ADDR_WIDTH'(i)) begin
              if (bus.write_in) regs_d[i] = apply_mode(bus.mode_in, regs_d[i], bus.data_in);
              else              rdata_d   = regs_q[i];
            end
          end
        end
      end
      ACK: begin
        if (!bus.enable_in) state_d = IDLE;
      end
    endcase
  end

  // State, read-capture and bank registers; synchronous reset wins over any request.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (rst_in) begin
      state_q <= IDLE;
      rdata_q <= '0;
      // NOTE: the bank is reset because it drives external enables; plain storage arrays normally stay unreset.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Handshake and read data are released to Z whenever they carry no meaning.
  assign bus.ready_out = bus.enable_in ? (state_q == ACK) : 1'bz;
  assign bus.data_out  = (bus.enable_in && !bus.write_in && state_q == ACK)
                         ? rdata_q : {DATA_WIDTH{1'bz}};

  // Flattened register image: register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_mem_out
    assign bus.mem_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_io_register_bank.sv
// Self-checking bench for io_register_bank (NUM_REGS=3 so address 3 is out of range).
// A behavioural model of the bank is compared against the DUT every cycle, and
// directed sequences pin the model with hand-computed literals.
module tb_io_register_bank;
  localparam int DW = 32;
  localparam int NR = 3;
  localparam int AW = 2;

  typedef logic [NR-1:0][DW-1:0] regs_t;

  logic clk_in = 1'b0;
  logic rst_in;
  bit   cmp_en = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk_in = ~clk_in;

  io_register_bank_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) bus ();

  io_register_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  // ---------------- behavioural model ----------------
  regs_t          m_regs;
  logic           m_acked;
  logic [DW-1:0]  m_rd;

  function automatic regs_t next_regs(input regs_t cur, input logic wr, input logic [AW-1:0] a,
                                      input logic [1:0] m, input logic [DW-1:0] d);
    regs_t         n = cur;
    logic [DW-1:0] base;
`ifdef IO_REGISTER_BANK_PULSE_EN
    n[NR-1] = '0;
`else
`endif
    if (wr && int'(a) < NR) begin
      base = n[a];
      case (m)
        2'b00: n[a] = d;
        2'b01: n[a] = base | d;
        2'b10: n[a] = base & ~d;
        default: n[a] = base ^ d;
      endcase
    end
    return n;
  endfunction

  // Model: one operation per enable pulse; a new one only after enable has dropped.
  always @(posedge clk_in) begin
    if (rst_in) begin
      m_regs  <= '0;
      m_acked <= 1'b0;
      m_rd    <= '0;
    end else if (bus.enable_in && !m_acked) begin
      m_acked <= 1'b1;
      m_regs  <= next_regs(m_regs, bus.write_in, bus.addr_in, bus.mode_in, bus.data_in);
      if (!bus.write_in) m_rd <= (int'(bus.addr_in) < NR) ? m_regs[bus.addr_in] : '0;
    end else begin
      m_regs <= next_regs(m_regs, 1'b0, '0, 2'b00, '0);
      if (!bus.enable_in) m_acked <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // A released output must read Z; a two-state simulator resolves that to 0.
  task automatic check_bus(input string name, input logic [DW-1:0] act,
                           input logic [DW-1:0] exp, input bit released);
    bit ok;
    n_checks++;
    ok = released ? (act === {DW{1'bz}} || act === '0) : (act === exp);
    if (ok) n_pass++;
    else if (released) $display("FAIL %s: got %h, expected Z (t=%0t)", name, act, $time);
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk_in) begin
    if (cmp_en) begin
      check("mem_out vs model", bus.mem_out, m_regs);
      check_bus("ready_out vs model", {DW{bus.ready_out}}, {DW{m_acked}}, !bus.enable_in);
      check_bus("data_out vs model", bus.data_out, m_rd,
                !(bus.enable_in && !bus.write_in && m_acked));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic en, input logic wr, input logic [AW-1:0] a,
                       input logic [1:0] m, input logic [DW-1:0] d);
    bus.enable_in = en;
    bus.write_in  = wr;
    bus.addr_in   = a;
    bus.mode_in   = m;
    bus.data_in   = d;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_op(input logic wr, input logic [AW-1:0] a, input logic [1:0] m,
                       input logic [DW-1:0] d, output logic [DW-1:0] rd, output logic rdy);
    drive(1'b1, wr, a, m, d);
    step();
    rdy = bus.ready_out;
    rd  = bus.data_out;
    drive(1'b0, 1'b0, '0, 2'b00, '0);
    step();
  endtask

  logic [DW-1:0] rd;
  logic          rdy;
  logic [1:0]    seq_mode [3] = '{2'b01, 2'b10, 2'b11};
  logic [DW-1:0] seq_data [3] = '{32'h0000_00F0, 32'h0000_000F, 32'hFFFF_0000};
  logic [DW-1:0] seq_exp  [3] = '{32'hA5A5_0FFF, 32'hA5A5_0FF0, 32'h5A5A_0FF0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1;
    drive(1'b0, 1'b0, '0, 2'b00, '0);
    step();
    step();
    rst_in = 1'b0;
    cmp_en = 1'b1;
    check("reset mem_out", bus.mem_out, 96'h0);

    for (int a = 0; a < 4; a++) begin
      do_op(1'b0, AW'(a), 2'b00, '0, rd, rdy);
      check($sformatf("reset read ack a%0d", a), rdy, 1'b1);
      check($sformatf("reset read data a%0d", a), rd, 32'h0);
    end

    do_op(1'b1, 2'd1, 2'b00, 32'hA5A5_0F0F, rd, rdy);
    check("load ack", rdy, 1'b1);
    check("load mem slice", bus.mem_out[63:32], 32'hA5A5_0F0F);
    do_op(1'b0, 2'd1, 2'b11, '0, rd, rdy);
    check("load readback", rd, 32'hA5A5_0F0F);

    for (int k = 0; k < 3; k++) begin
      do_op(1'b1, 2'd1, seq_mode[k], seq_data[k], rd, rdy);
      check($sformatf("mode %0d mem slice", seq_mode[k]), bus.mem_out[63:32], seq_exp[k]);
    end

    // Enable held five cycles with one toggle request: exactly one toggle.
    drive(1'b1, 1'b1, 2'd0, 2'b11, 32'h1);
    check("hold ready c1", bus.ready_out, 1'b0);
    for (int c = 2; c <= 5; c++) begin
      step();
      check($sformatf("hold ready c%0d", c), bus.ready_out, 1'b1);
    end
    drive(1'b0, 1'b0, '0, 2'b00, '0);
    step();
    check("hold single toggle", bus.mem_out[31:0], 32'h1);

    do_op(1'b1, 2'd3, 2'b00, 32'hDEAD_BEEF, rd, rdy);
    check("oob write ack", rdy, 1'b1);
    check("oob write mem", bus.mem_out, 96'h00000000_5A5A0FF0_00000001);
    do_op(1'b0, 2'd3, 2'b00, '0, rd, rdy);
    check("oob read data", rd, 32'h0);

    // Reset while in ACK with enable still high.
    drive(1'b1, 1'b1, 2'd1, 2'b00, 32'h1234_5678);
    step();
    rst_in = 1'b1;
    step();
    check("reset in ack ready", bus.ready_out, 1'b0);
    check("reset in ack mem", bus.mem_out, 96'h0);
    rst_in = 1'b0;
    drive(1'b0, 1'b0, '0, 2'b00, '0);
    step();

    // Strobe behaviour of the last register.
    drive(1'b1, 1'b1, 2'(NR-1), 2'b00, 32'h5);
    step();
    check("last reg after load", bus.mem_out[95:64], 32'h5);
    drive(1'b0, 1'b0, '0, 2'b00, '0);
    step();
`ifdef IO_REGISTER_BANK_PULSE_EN
    check("last reg one cycle later", bus.mem_out[95:64], 32'h0);
`else
    check("last reg one cycle later", bus.mem_out[95:64], 32'h5);
`endif

    // Randomized traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 400; n++) begin
      rst_in = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0) ? 32'(1 << $urandom_range(0, 31)) : 32'($urandom));
      step();
    end
    rst_in = 1'b0;
    drive(1'b0, 1'b0, '0, 2'b00, '0);
    step();
    step();
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
